cla28_share_arbiter: RTL and testbench

//  Shares one CLA28bit adder instance among N_REQ requesters; each request carries
//  two 28-bit operands. Work-conserving arbitration: at most one grant per cycle.
//  The sum is registered once and returned on a valid/ready response channel,

---
 rtl/cla28_arb_pkg.sv | 14 +
 rtl/cla28_share_arbiter_cla.sv | 61 ++++++
 rtl/cla28_share_arbiter_rr.sv | 32 +++
 rtl/cla28_share_arbiter.sv | 130 +++++++++++++
 tb/tb_cla28_share_arbiter.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cla28_arb_pkg.sv
// Shared types and helpers for the CLA28 share arbiter.
// Build option: CLA28_ARB_PRIO0_EN gives requester 0 strict priority.
package cla28_arb_pkg;
  localparam int DATA_W = 28;

  typedef logic [DATA_W-1:0] opnd_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/cla28_share_arbiter_cla.sv
// 28-bit carry-lookahead adder: 4-bit groups, group carries from lookahead.
// Carry-out is not produced; the sum wraps modulo 2^28.
module CLA28bit
  import cla28_arb_pkg::*;
(
  input  opnd_t a,
  input  opnd_t b,
  output opnd_t sum
);
  localparam int NB = DATA_W / 4;

  logic [DATA_W-1:0] w_g;
  logic [DATA_W-1:0] w_p;
  logic [DATA_W-1:0] w_c;
  logic [NB-1:0]     w_bg;
  logic [NB-1:0]     w_bp;
  logic [NB-1:0]     w_bc;

  assign w_g = a & b;
  assign w_p = a ^ b;

  always_comb begin
    w_bg = '0;
    w_bp = '0;
    for (int j = 0; j < NB; j++) begin
      w_bg[j] = w_g[4*j+3]
              | (w_p[4*j+3] & w_g[4*j+2])
              | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
              | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
      w_bp[j] = &w_p[4*j +: 4];
    end
  end

  // Group carry-in is a lookahead over all lower groups (carry-in 0).
  always_comb begin
    logic acc;
    w_bc = '0;
    for (int j = 0; j < NB; j++) begin
      acc = 1'b0;
      for (int k = 0; k < j; k++) acc = w_bg[k] | (w_bp[k] & acc);
      w_bc[j] = acc;
    end
  end

  always_comb begin
    w_c = '0;
    for (int j = 0; j < NB; j++) begin
      w_c[4*j]   = w_bc[j];
      w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_bc[j]);
      w_c[4*j+2] = w_g[4*j+1]
                 | (w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+1] & w_p[4*j] & w_bc[j]);
      w_c[4*j+3] = w_g[4*j+2]
                 | (w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                 | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_bc[j]);
    end
  end

  assign sum = w_p ^ w_c;
endmodule

// File: rtl/cla28_share_arbiter_rr.sv
// Mask-based round-robin arbiter: search from ptr upward, wrap to 0.
// Outputs a one-hot grant and its encoded index; all zero when en=0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_sel;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) w_mask[i] = (IW'(i) >= ptr);
  end

  assign w_hi  = req & w_mask;
  assign w_sel = (|w_hi) ? w_hi : req;
  assign gnt   = en ? (w_sel & (~w_sel + N'(1))) : '0;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) idx = IW'(i);
    end
  end
endmodule

// File: rtl/cla28_share_arbiter.sv
// One CLA28bit shared by N_REQ requesters with a registered, tagged response.
// Build option: CLA28_ARB_PRIO0_EN gives requester 0 strict priority.
module cla28_share_arbiter
  import cla28_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output opnd_t                   rsp_sum,
  output logic [ID_W-1:0]         rsp_id,
  output logic [N_REQ*CNT_W-1:0]  grant_cnt,
  output logic                    busy
);
  if (ID_W != clog2(N_REQ)) begin : g_id_w_chk
    $error("ID_W must equal clog2(N_REQ)");
  end

  logic                   r_rsp_valid;
  opnd_t                  r_rsp_sum;
  logic [ID_W-1:0]        r_rsp_id;
  logic [ID_W-1:0]        r_ptr;
  logic [CNT_W-1:0]       r_cnt [N_REQ];

  logic                   w_free;
  logic                   w_en;
  logic [N_REQ-1:0]       w_rr_req;
  logic                   w_rr_en;
  logic [N_REQ-1:0]       w_rr_gnt;
  logic [ID_W-1:0]        w_rr_idx;
  logic [N_REQ-1:0]       w_gnt;
  logic [ID_W-1:0]        w_idx;
  logic                   w_any;
  logic [ID_W-1:0]        w_ptr_nxt;
  opnd_t                  w_a;
  opnd_t                  w_b;
  opnd_t                  w_sum;

  assign w_free = ~r_rsp_valid | rsp_ready;
  assign w_en   = w_free & rst_n;

`ifdef CLA28_ARB_PRIO0_EN
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(1);
  logic w_p0;
  // Requester 0 bypasses the ring; the ring only ever sees 1..N_REQ-1.
  assign w_p0     = w_en & req_valid[0];
  assign w_rr_req = req_valid & ~N_REQ'(1);
  assign w_rr_en  = w_en & ~req_valid[0];
  assign w_gnt    = w_p0 ? N_REQ'(1) : w_rr_gnt;
  assign w_idx    = w_p0 ? '0 : w_rr_idx;
`else
  localparam logic [ID_W-1:0] PTR_RST = '0;
  assign w_rr_req = req_valid;
  assign w_rr_en  = w_en;
  assign w_gnt    = w_rr_gnt;
  assign w_idx    = w_rr_idx;
`endif

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .req (w_rr_req),
    .ptr (r_ptr),
    .en  (w_rr_en),
    .gnt (w_rr_gnt),
    .idx (w_rr_idx)
  );

  assign w_any     = |w_gnt;
  assign w_ptr_nxt = (w_rr_idx == ID_W'(N_REQ - 1)) ? PTR_RST
                                                    : w_rr_idx + ID_W'(1);

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt[i]) begin
        w_a = w_a | req_a[DATA_W*i +: DATA_W];
        w_b = w_b | req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  CLA28bit u_cla (
    .a   (w_a),
    .b   (w_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_id    <= '0;
      r_ptr       <= PTR_RST;
      for (int i = 0; i < N_REQ; i++) r_cnt[i] <= '0;
    end else begin
      if (w_free) begin
        r_rsp_valid <= w_any;
        if (w_any) begin
          r_rsp_sum <= w_sum;
          r_rsp_id  <= w_idx;
        end
      end
      if (|w_rr_gnt) r_ptr <= w_ptr_nxt;
      for (int i = 0; i < N_REQ; i++) begin
        if (w_gnt[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[CNT_W*g +: CNT_W] = r_cnt[g];
  end

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_rsp_valid | (|req_valid);
endmodule

// File: tb/tb_cla28_share_arbiter.sv
// Directed, table-driven bench for cla28_share_arbiter (N_REQ=4).
// Build option: CLA28_ARB_PRIO0_EN switches the priority expectations.
module tb_cla28_share_arbiter;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid;
  logic [111:0] req_a;
  logic [111:0] req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [27:0]  rsp_sum;
  logic [1:0]   rsp_id;
  logic [63:0]  grant_cnt;
  logic         busy;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]   v;
    logic [111:0] a;
    logic [111:0] b;
    logic         rdy;
    logic [3:0]   er;
    logic         ev;
    logic [27:0]  es;
    logic [1:0]   eid;
  } vec_t;

  vec_t tbl[$];

  cla28_share_arbiter #(
    .N_REQ (4),
    .ID_W  (2),
    .CNT_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id),
    .grant_cnt (grant_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [111:0] a,
                     input logic [111:0] b, input logic rdy,
                     input logic [3:0] er, input logic ev,
                     input logic [27:0] es, input logic [1:0] eid);
    vec_t t;
    t.v = v; t.a = a; t.b = b; t.rdy = rdy;
    t.er = er; t.ev = ev; t.es = es; t.eid = eid;
    tbl.push_back(t);
  endtask

  function automatic logic [15:0] cnt(input int k);
    return grant_cnt[16*k +: 16];
  endfunction

  initial begin
    logic [111:0] a4;
    logic [111:0] b4;
    int r;

    a4 = {28'h400, 28'h300, 28'h200, 28'h100};
    b4 = {28'd3, 28'd2, 28'd1, 28'd0};
    for (int k = 0; k < 8; k++) begin
`ifdef CLA28_ARB_PRIO0_EN
      r = 0;
`else
      r = k % 4;
`endif
      add(4'hF, a4, b4, 1'b1, 4'(1 << r), 1'b1,
          28'(32'h100 * (r + 1) + r), 2'(r));
    end
    add(4'b0001,
        {28'h1234567, 28'hABCDEF0, 28'h5555555, 28'hFFFFFFF},
        {28'h7654321, 28'h0FEDCBA, 28'h2222222, 28'h0000001},
        1'b1, 4'b0001, 1'b1, 28'h0000000, 2'd0);
    add(4'b0100,
        {28'h1111111, 28'h8000000, 28'h3333333, 28'h4444444},
        {28'h9999999, 28'h7FFFFFF, 28'hAAAAAAA, 28'hBBBBBBB},
        1'b1, 4'b0100, 1'b1, 28'hFFFFFFF, 2'd2);
    add(4'b0000, {4{28'hDEADBEE}}, {4{28'h0C0FFEE}},
        1'b1, 4'b0000, 1'b0, 28'hFFFFFFF, 2'd2);

    // Reset state, with requests pending to prove req_ready is gated.
    req_valid = 4'hF;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    #12;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_sum", 32'(rsp_sum), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_cnt", grant_cnt[31:0], 32'h0);
    req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single request, 1-cycle latency.
    @(posedge clk); #1;
    req_valid = 4'b0001;
    req_a = {84'h0, 28'h0000005};
    req_b = {84'h0, 28'h0000003};
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("t1_valid", 32'(rsp_valid), 32'h1);
    chk("t1_sum", 32'(rsp_sum), 32'h8);
    chk("t1_id", 32'(rsp_id), 32'h0);
    chk("t1_cnt0", 32'(cnt(0)), 32'h1);

    req_valid = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      req_valid = tbl[i].v;
      req_a = tbl[i].a;
      req_b = tbl[i].b;
      rsp_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(rsp_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d_sum", i), 32'(rsp_sum), 32'(tbl[i].es));
      chk($sformatf("v%0d_id", i), 32'(rsp_id), 32'(tbl[i].eid));
      if (i == 7) begin
`ifdef CLA28_ARB_PRIO0_EN
        chk("rr_cnt0", 32'(cnt(0)), 32'd8);
        chk("rr_cnt3", 32'(cnt(3)), 32'd0);
`else
        for (int k = 0; k < 4; k++)
          chk($sformatf("rr_cnt%0d", k), 32'(cnt(k)), 32'd2);
`endif
      end
    end

    // Backpressure: hold for 5 cycles, then drain and refill together.
    req_valid = 4'b0110;
    req_a = {28'h0, 28'h33, 28'h11, 28'h0};
    req_b = {28'h0, 28'h44, 28'h22, 28'h0};
    rsp_ready = 1'b0;
    #1;
    chk("bp_first_ready", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    chk("bp_first_sum", 32'(rsp_sum), 32'h33);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'h0);
      chk($sformatf("bp%0d_vs", c), {3'b0, rsp_valid, rsp_sum},
          {4'h1, 28'h33});
      chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'h1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    chk("bp_rel_sum", 32'(rsp_sum), 32'h77);
    chk("bp_rel_id", 32'(rsp_id), 32'h2);
`ifdef CLA28_ARB_PRIO0_EN
    chk("bp_cnt1", 32'(cnt(1)), 32'd1);
    chk("bp_cnt2", 32'(cnt(2)), 32'd2);
`else
    chk("bp_cnt1", 32'(cnt(1)), 32'd3);
    chk("bp_cnt2", 32'(cnt(2)), 32'd4);
`endif

    // Asynchronous reset with a response pending.
    rsp_ready = 1'b0;
    #2;
    chk("mr_pre_valid", 32'(rsp_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_cnt", grant_cnt[31:0], 32'h0);
    chk("mr_cnt_hi", grant_cnt[63:32], 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h0);
    req_valid = 4'h0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mr_no_stale", 32'(rsp_valid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);

    // Counter wrap on requester 2 at full throughput.
    req_valid = 4'b0100;
    req_a = {28'h0, 28'h1, 28'h0, 28'h0};
    req_b = {28'h0, 28'h2, 28'h0, 28'h0};
    repeat (65535) @(posedge clk);
    #1;
    chk("wr_cnt2_max", 32'(cnt(2)), 32'hFFFF);
    chk("wr_sum", 32'(rsp_sum), 32'h3);
    @(posedge clk); #1;
    chk("wr_cnt2_wrap", 32'(cnt(2)), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
